// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and baud arithmetic
package uart_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_SEND_BYTE,
      S_STOP
   } tx_state_t;

   // Clocks per serial bit; the receiver uses the same rounding so both ends agree.
   function automatic int unsigned uart_cycle(input int unsigned clk_fre,
                                              input int unsigned baud_rate);
      return (clk_fre * 32'd1000000) / baud_rate;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO with wrap-bit pointers and registered full/empty
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign do_push = push_i && !full_q;
   assign do_pop  = pop_i && !empty_q;

   // Flags are computed from next-state pointers so they can be registered.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      empty_d = (wr_ptr_d == rd_ptr_d);
      full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter fed from a small byte FIFO
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FRE    = 50,
   parameter int BAUD_RATE  = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [7:0] tx_data,
   input  logic       tx_data_valid,
   output logic       tx_data_ready,
   output logic       tx_busy,
   output logic       tx_pin
);

   localparam int unsigned CYCLE      = uart_cycle(CLK_FRE, BAUD_RATE);
   localparam logic [15:0] CYCLE_LAST = 16'(CYCLE - 1);

   tx_state_t   state_q;
   logic [15:0] cycle_cnt_q;
   logic [2:0]  bit_cnt_q;
   logic [7:0]  tx_bits_q;
   logic        tx_pin_q;
   logic        tx_busy_q;

   logic        fifo_full, fifo_empty, fifo_pop, push;
   logic [7:0]  fifo_rdata;
   logic        bit_last;

   assign push     = tx_data_valid && tx_data_ready;
   assign bit_last = (cycle_cnt_q == CYCLE_LAST);
   assign fifo_pop = !fifo_empty &&
                     ((state_q == S_IDLE) || (state_q == S_STOP && bit_last));

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .push_i  (push),
      .wdata_i (tx_data),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Busy tracks the next state: it only drops when entering idle with no byte arriving.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         cycle_cnt_q <= '0;
         bit_cnt_q   <= '0;
         tx_bits_q   <= '0;
         tx_pin_q    <= 1'b1;
         tx_busy_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               cycle_cnt_q <= '0;
               if (!fifo_empty) begin
                  state_q   <= S_START;
                  tx_bits_q <= fifo_rdata;
                  tx_pin_q  <= 1'b0;
                  tx_busy_q <= 1'b1;
               end else begin
                  tx_pin_q  <= 1'b1;
                  tx_busy_q <= push;
               end
            end
            S_START: begin
               tx_busy_q <= 1'b1;
               if (bit_last) begin
                  state_q     <= S_SEND_BYTE;
                  cycle_cnt_q <= '0;
                  bit_cnt_q   <= '0;
                  tx_pin_q    <= tx_bits_q[0];
               end else begin
                  cycle_cnt_q <= cycle_cnt_q + 16'd1;
               end
            end
            S_SEND_BYTE: begin
               tx_busy_q <= 1'b1;
               if (bit_last) begin
                  cycle_cnt_q <= '0;
                  if (bit_cnt_q == 3'd7) begin
                     state_q  <= S_STOP;
                     tx_pin_q <= 1'b1;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     tx_pin_q  <= tx_bits_q[bit_cnt_q + 3'd1];
                  end
               end else begin
                  cycle_cnt_q <= cycle_cnt_q + 16'd1;
               end
            end
            S_STOP: begin
               if (bit_last) begin
                  cycle_cnt_q <= '0;
                  if (!fifo_empty) begin
                     state_q   <= S_START;
                     tx_bits_q <= fifo_rdata;
                     tx_pin_q  <= 1'b0;
                     tx_busy_q <= 1'b1;
                  end else begin
                     state_q   <= S_IDLE;
                     tx_pin_q  <= 1'b1;
                     tx_busy_q <= push;
                  end
               end else begin
                  cycle_cnt_q <= cycle_cnt_q + 16'd1;
                  tx_busy_q   <= 1'b1;
               end
            end
            default: begin
               state_q  <= S_IDLE;
               tx_pin_q <= 1'b1;
            end
         endcase
      end
   end

   assign tx_data_ready = !fifo_full;
   assign tx_busy       = tx_busy_q;
   assign tx_pin        = tx_pin_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized self-checking bench for uart_tx with a line-decoding receiver model
module tb_uart_tx;

   localparam int CYC   = 10;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_data_valid = 1'b0;
   logic       tx_data_ready, tx_busy, tx_pin;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0] pb [16];
   int         pacc [16];
   logic [7:0] exp_q [$];
   logic [7:0] rx_q [$];
   int         rx_start_q [$];
   logic [9:0] rx_bits_q [$];
   int         frame_errs = 0;

   logic       mon_active = 1'b0;
   int         mon_off = 0;
   int         mon_start = 0;
   logic [9:0] mon_bits = '0;

   uart_tx #(
      .CLK_FRE    (1),
      .BAUD_RATE  (100000),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .tx_data       (tx_data),
      .tx_data_valid (tx_data_valid),
      .tx_data_ready (tx_data_ready),
      .tx_busy       (tx_busy),
      .tx_pin        (tx_pin)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Receiver model: falling edge marks a start bit, then sample each bit at its centre.
   initial begin
      forever begin
         @(negedge clk);
         if (!rstn) begin
            mon_active = 1'b0;
         end else begin
            if (!mon_active && tx_pin === 1'b0) begin
               mon_active = 1'b1;
               mon_off    = 0;
               mon_start  = cyc;
            end
            if (mon_active) begin
               if (mon_off % CYC == CYC / 2) mon_bits[mon_off / CYC] = tx_pin;
               if (mon_off == 9 * CYC + CYC / 2) begin
                  rx_q.push_back(mon_bits[8:1]);
                  rx_start_q.push_back(mon_start);
                  rx_bits_q.push_back(mon_bits);
                  if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) frame_errs++;
                  mon_active = 1'b0;
               end
               mon_off++;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      rx_q.delete();
      rx_start_q.delete();
      rx_bits_q.delete();
      exp_q.delete();
      frame_errs = 0;
   endtask

   task automatic push_n(input int n);
      int   i;
      int   guard;
      logic rdy;
      i = 0;
      guard = 0;
      while (i < n && guard < 1000) begin
         tx_data_valid = 1'b1;
         tx_data = pb[i];
         rdy = tx_data_ready;
         tick();
         guard++;
         if (rdy) begin
            pacc[i] = cyc;
            exp_q.push_back(pb[i]);
            i++;
         end
      end
      tx_data_valid = 1'b0;
      tx_data = 8'($urandom);
      checks++;
      if (i != n) begin
         errors++;
         $display("FAIL push_timeout: accepted %0d bytes, required %0d", i, n);
      end
   endtask

   task automatic wait_idle(input int budget, output int fall);
      int n;
      n = 0;
      while (n < budget && (tx_busy !== 1'b0 || mon_active)) begin
         tick();
         n++;
      end
      fall = cyc;
      checks++;
      if (tx_busy !== 1'b0 || mon_active) begin
         errors++;
         $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", tx_busy, n);
      end
   endtask

   task automatic test_reset();
      int bad;
      rstn = 1'b0;
      tx_data_valid = 1'b0;
      repeat (3) tick();
      checks++;
      if (tx_pin !== 1'b1) begin errors++; $display("FAIL reset_pin: got %b, required 1", tx_pin); end
      checks++;
      if (tx_data_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", tx_data_ready); end
      checks++;
      if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", tx_busy); end
      rstn = 1'b1;
      bad = 0;
      repeat (50) begin
         tick();
         if (tx_pin !== 1'b1 || tx_data_ready !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL reset_idle: %0d bad cycles, required 0", bad); end
   endtask

   task automatic test_single();
      int fall;
      int st;
      clear_mon();
      pb[0] = 8'hA5;
      push_n(1);
      wait_idle(400, fall);
      checks++;
      if (rx_q.size() != 1) begin
         errors++;
         $display("FAIL single_count: got %0d frames, required 1", rx_q.size());
      end else begin
         st = rx_start_q[0];
         checks++;
         if (st != pacc[0] + 1) begin errors++; $display("FAIL single_latency: start at %0d, required %0d", st, pacc[0] + 1); end
         checks++;
         if (rx_bits_q[0] !== 10'b11_0100_1010) begin errors++; $display("FAIL single_bits: got %b, required 1101001010", rx_bits_q[0]); end
         checks++;
         if (rx_q[0] !== 8'hA5) begin errors++; $display("FAIL single_byte: got %h, required a5", rx_q[0]); end
         checks++;
         if (fall != st + 10 * CYC) begin errors++; $display("FAIL single_busy_fall: at %0d, required %0d", fall, st + 10 * CYC); end
      end
      checks++;
      if (frame_errs != 0) begin errors++; $display("FAIL single_framing: %0d bad frames, required 0", frame_errs); end
   endtask

   task automatic test_back_to_back();
      int fall;
      for (int r = 0; r < 2; r++) begin
         clear_mon();
         if (r == 0) begin
            pb[0] = 8'h00; pb[1] = 8'hFF; pb[2] = 8'h55;
         end else begin
            for (int k = 0; k < 3; k++) pb[k] = 8'($urandom);
         end
         push_n(3);
         wait_idle(800, fall);
         checks++;
         if (rx_q.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d frames, required 3", rx_q.size());
         end else begin
            for (int k = 0; k < 3; k++) begin
               checks++;
               if (rx_q[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_byte%0d: got %h, required %h", k, rx_q[k], exp_q[k]); end
            end
            for (int k = 1; k < 3; k++) begin
               checks++;
               if (rx_start_q[k] - rx_start_q[k-1] != 10 * CYC) begin
                  errors++;
                  $display("FAIL b2b_gap%0d: spacing %0d, required %0d", k, rx_start_q[k] - rx_start_q[k-1], 10 * CYC);
               end
            end
            checks++;
            if (fall - rx_start_q[0] != 30 * CYC) begin errors++; $display("FAIL b2b_total: %0d cycles, required %0d", fall - rx_start_q[0], 30 * CYC); end
         end
         checks++;
         if (frame_errs != 0) begin errors++; $display("FAIL b2b_framing: %0d bad frames, required 0", frame_errs); end
      end
   endtask

   task automatic test_hold_valid();
      int fall;
      clear_mon();
      for (int k = 0; k < 7; k++) pb[k] = 8'($urandom);
      push_n(7);
      wait_idle(1500, fall);
      // The first pop frees a slot one cycle after the first push, so DEPTH+1 bytes go in back to back.
      checks++;
      if (pacc[4] - pacc[0] != DEPTH) begin errors++; $display("FAIL hold_fill: span %0d, required %0d", pacc[4] - pacc[0], DEPTH); end
      checks++;
      if (rx_q.size() != 7) begin
         errors++;
         $display("FAIL hold_count: got %0d frames, required 7", rx_q.size());
      end else begin
         checks++;
         if (pacc[5] != rx_start_q[1] + 1) begin errors++; $display("FAIL hold_ready1: accept at %0d, required %0d", pacc[5], rx_start_q[1] + 1); end
         checks++;
         if (pacc[6] != rx_start_q[2] + 1) begin errors++; $display("FAIL hold_ready2: accept at %0d, required %0d", pacc[6], rx_start_q[2] + 1); end
         for (int k = 0; k < 7; k++) begin
            checks++;
            if (rx_q[k] !== exp_q[k]) begin errors++; $display("FAIL hold_byte%0d: got %h, required %h", k, rx_q[k], exp_q[k]); end
         end
         checks++;
         if (fall - rx_start_q[0] != 70 * CYC) begin errors++; $display("FAIL hold_total: %0d cycles, required %0d", fall - rx_start_q[0], 70 * CYC); end
      end
   endtask

   task automatic test_push_on_pop();
      int fall;
      int start_a;
      int guard;
      clear_mon();
      pb[0] = 8'($urandom);
      pb[1] = 8'($urandom);
      push_n(2);
      start_a = pacc[0] + 1;
      guard = 0;
      while (cyc < start_a + 10 * CYC - 1 && guard < 500) begin tick(); guard++; end
      for (int k = 0; k < 5; k++) pb[k] = 8'($urandom);
      push_n(5);
      wait_idle(1500, fall);
      checks++;
      if (pacc[3] - pacc[0] != 3) begin errors++; $display("FAIL pop_push_fill: span %0d, required 3", pacc[3] - pacc[0]); end
      checks++;
      if (rx_q.size() != 7) begin
         errors++;
         $display("FAIL pop_push_count: got %0d frames, required 7", rx_q.size());
      end else begin
         checks++;
         if (pacc[0] != rx_start_q[1]) begin errors++; $display("FAIL pop_push_same_edge: push at %0d, required %0d", pacc[0], rx_start_q[1]); end
         checks++;
         if (pacc[4] != rx_start_q[2] + 1) begin errors++; $display("FAIL pop_push_ready: accept at %0d, required %0d", pacc[4], rx_start_q[2] + 1); end
         for (int k = 0; k < 7; k++) begin
            checks++;
            if (rx_q[k] !== exp_q[k]) begin errors++; $display("FAIL pop_push_byte%0d: got %h, required %h", k, rx_q[k], exp_q[k]); end
         end
         checks++;
         if (fall - rx_start_q[0] != 70 * CYC) begin errors++; $display("FAIL pop_push_total: %0d cycles, required %0d", fall - rx_start_q[0], 70 * CYC); end
      end
   endtask

   task automatic test_reset_mid();
      int target;
      int guard;
      int bad;
      clear_mon();
      pb[0] = 8'($urandom) & 8'hEF;
      pb[1] = 8'($urandom);
      push_n(2);
      target = pacc[0] + 1 + 5 * CYC + 3;
      guard = 0;
      while (cyc < target && guard < 500) begin tick(); guard++; end
      checks++;
      if (tx_pin !== 1'b0) begin errors++; $display("FAIL rst_mid_bit4: got %b, required 0", tx_pin); end
      #2;
      rstn = 1'b0;
      #1;
      checks++;
      if (tx_pin !== 1'b1) begin errors++; $display("FAIL rst_mid_pin: got %b, required 1", tx_pin); end
      checks++;
      if (tx_busy !== 1'b0 || tx_data_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_flags: busy=%b ready=%b, required 0 1", tx_busy, tx_data_ready);
      end
      tick();
      tick();
      rstn = 1'b1;
      bad = 0;
      repeat (300) begin
         tick();
         if (tx_pin !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rst_mid_quiet: %0d active cycles, required 0", bad); end
      checks++;
      if (rx_q.size() != 0) begin errors++; $display("FAIL rst_mid_frames: got %0d frames, required 0", rx_q.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_hold_valid();
      test_push_on_pop();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
